// File: rtl/fft_frame_sequencer.sv
// Frame scheduler between the FFT result bus and a byte-wide SPI master: sync, counter, 2N data words[, checksum].
// Optional trailing checksum byte when FFT_FRAME_CHECKSUM_EN is defined.
module fft_frame_sequencer #(
  parameter int              N         = 16,
  parameter int              MSB       = 8,
  parameter logic [MSB-1:0]  SYNC_BYTE = 8'hA5
) (
  input  logic               clk,
  input  logic               i_Rst_L,
  input  logic [N*2*MSB-1:0] data_bus,
  input  logic               fft_done,
  input  logic               tx_ready,
  output logic [MSB-1:0]     tx_byte,
  output logic               tx_dv,
  output logic               busy,
  output logic               frame_sent,
  output logic               overrun,
  input  logic               clr_overrun
);

  localparam int WORDS = 2 * N;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_CNT,
    S_DATA,
    S_CSUM,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [N*2*MSB-1:0]   snap_q, snap_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [MSB-1:0]       cnt_q, cnt_d;
  logic [MSB-1:0]       tx_byte_q, tx_byte_d;
  logic                 tx_dv_q, tx_dv_d;
  logic                 armed_q, armed_d;
  logic                 overrun_q, overrun_d;
  logic [MSB-1:0]       cur_word;
  logic                 can_issue;
`ifdef FFT_FRAME_CHECKSUM_EN
  logic [MSB-1:0]       sum_q, sum_d;
`endif

  assign cur_word  = snap_q[int'(idx_q)*MSB +: MSB];
  // The SPI master must show ready low before we strobe it again.
  assign can_issue = tx_ready && armed_q;

  always_comb begin
    state_d   = state_q;
    snap_d    = snap_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    tx_byte_d = tx_byte_q;
    tx_dv_d   = 1'b0;
    armed_d   = armed_q;
    overrun_d = overrun_q;
`ifdef FFT_FRAME_CHECKSUM_EN
    sum_d     = sum_q;
`endif

    if (!tx_ready) armed_d = 1'b1;

    if (clr_overrun) overrun_d = 1'b0;
    if (fft_done && state_q != S_IDLE) overrun_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (fft_done) begin
          snap_d  = data_bus;
          idx_d   = '0;
          state_d = S_HDR;
        end
      end
      S_HDR: begin
        if (can_issue) begin
          tx_byte_d = SYNC_BYTE;
          tx_dv_d   = 1'b1;
          armed_d   = 1'b0;
          state_d   = S_CNT;
        end
      end
      S_CNT: begin
        if (can_issue) begin
          tx_byte_d = cnt_q;
          tx_dv_d   = 1'b1;
          armed_d   = 1'b0;
          state_d   = S_DATA;
`ifdef FFT_FRAME_CHECKSUM_EN
          sum_d     = cnt_q;
`endif
        end
      end
      S_DATA: begin
        if (can_issue) begin
          tx_byte_d = cur_word;
          tx_dv_d   = 1'b1;
          armed_d   = 1'b0;
`ifdef FFT_FRAME_CHECKSUM_EN
          sum_d     = sum_q + cur_word;
`endif
          if (idx_q == IDX_W'(WORDS - 1)) begin
`ifdef FFT_FRAME_CHECKSUM_EN
            state_d = S_CSUM;
`else
            state_d = S_DONE;
`endif
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
`ifdef FFT_FRAME_CHECKSUM_EN
      S_CSUM: begin
        if (can_issue) begin
          tx_byte_d = sum_q;
          tx_dv_d   = 1'b1;
          armed_d   = 1'b0;
          state_d   = S_DONE;
        end
      end
`endif
      S_DONE: begin
        cnt_d   = cnt_q + 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q   <= S_IDLE;
      snap_q    <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      tx_byte_q <= '0;
      tx_dv_q   <= 1'b0;
      armed_q   <= 1'b1;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      snap_q    <= snap_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      tx_byte_q <= tx_byte_d;
      tx_dv_q   <= tx_dv_d;
      armed_q   <= armed_d;
      overrun_q <= overrun_d;
    end
  end

`ifdef FFT_FRAME_CHECKSUM_EN
  always_ff @(posedge clk or negedge i_Rst_L) begin
    if (!i_Rst_L) sum_q <= '0;
    else          sum_q <= sum_d;
  end
`endif

  assign tx_byte    = tx_byte_q;
  assign tx_dv      = tx_dv_q;
  assign busy       = (state_q != S_IDLE);
  assign frame_sent = (state_q == S_DONE);
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Randomized bench for fft_frame_sequencer (N=4, MSB=8) against a frame-level reference model.
module tb_fft_frame_sequencer;

  localparam int N   = 4;
  localparam int MSB = 8;
  localparam int W   = N * 2 * MSB;

  logic           clk = 1'b0;
  logic           i_Rst_L = 1'b0;
  logic [W-1:0]   data_bus = '0;
  logic           fft_done = 1'b0;
  logic           tx_ready = 1'b1;
  logic           clr_overrun = 1'b0;
  logic [MSB-1:0] tx_byte;
  logic           tx_dv, busy, frame_sent, overrun;

  fft_frame_sequencer #(.N(N), .MSB(MSB), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .i_Rst_L(i_Rst_L), .data_bus(data_bus), .fft_done(fft_done),
    .tx_ready(tx_ready), .tx_byte(tx_byte), .tx_dv(tx_dv), .busy(busy),
    .frame_sent(frame_sent), .overrun(overrun), .clr_overrun(clr_overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // SPI master model and byte monitor, evaluated away from the active edge.
  logic [7:0] rx_q[$];
  int  sent_cnt = 0;
  int  rise_dly = 16;
  int  tmr = 0;
  bit  dv_since_low = 1'b0;

  always @(negedge clk) begin
    if (!tx_ready || !i_Rst_L) dv_since_low = 1'b0;
    if (tx_dv) begin
      check_eq("dv_spacing", {31'd0, dv_since_low}, 32'd0);
      dv_since_low = 1'b1;
      rx_q.push_back(tx_byte);
    end
    if (frame_sent) sent_cnt++;
    if (tx_dv) begin
      tx_ready = 1'b0;
      tmr = rise_dly;
    end else if (!tx_ready) begin
      if (tmr <= 1) tx_ready = 1'b1;
      else tmr--;
    end
  end

  logic [7:0] exp_cnt = 8'd0;
  bit         exp_ovr = 1'b0;

  // mode: 0 plain, 1 bus overwritten mid-frame, 2 dropped fft_done, 3 dropped fft_done + clear same cycle
  task automatic run_frame(input logic [W-1:0] bus, input int mode);
    logic [7:0] exp_q[$];
    logic [7:0] sum;
    int k;
    int s0;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    exp_q.push_back(exp_cnt);
    sum = exp_cnt;
    for (int i = 0; i < 2 * N; i++) begin
      exp_q.push_back(bus[i*MSB +: MSB]);
      sum = sum + bus[i*MSB +: MSB];
    end
`ifdef FFT_FRAME_CHECKSUM_EN
    exp_q.push_back(sum);
`endif
    rx_q.delete();
    s0 = sent_cnt;
    data_bus = bus;
    fft_done = 1'b1;
    @(negedge clk);
    fft_done = 1'b0;
    check_eq("busy_after_accept", {31'd0, busy}, 32'd1);
    k = 0;
    while (!frame_sent && k < 3000) begin
      if (k == 2 && mode == 1) data_bus = '1;
      if (k == 2 && mode >= 2) begin
        fft_done = 1'b1;
        if (mode == 3) clr_overrun = 1'b1;
        exp_ovr = 1'b1;
      end
      @(negedge clk);
      fft_done = 1'b0;
      clr_overrun = 1'b0;
      k++;
    end
    check_eq("frame_sent_seen", {31'd0, frame_sent}, 32'd1);
    @(negedge clk);
    check_eq("busy_after_frame", {31'd0, busy}, 32'd0);
    check_eq("frame_sent_once", sent_cnt - s0, 32'd1);
    check_eq("frame_len", rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      check_eq($sformatf("byte%0d_cnt%0h", i, exp_cnt), {24'd0, rx_q[i]}, {24'd0, exp_q[i]});
    check_eq("overrun_flag", {31'd0, overrun}, {31'd0, exp_ovr});
    exp_cnt = exp_cnt + 8'd1;
  endtask

  function automatic logic [W-1:0] rand_bus();
    return {$urandom, $urandom};
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] seq_bus;
    int k;
    int s0;
    seq_bus = 64'h0807_0605_0403_0201;

    repeat (3) @(negedge clk);
    check_eq("rst_tx_byte", {24'd0, tx_byte}, 32'd0);
    check_eq("rst_tx_dv", {31'd0, tx_dv}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_frame_sent", {31'd0, frame_sent}, 32'd0);
    check_eq("rst_overrun", {31'd0, overrun}, 32'd0);
    i_Rst_L = 1'b1;
    @(negedge clk);

    // Sequential words on the first frame (counter 00), then counter 01.
    run_frame(seq_bus, 0);
    run_frame(rand_bus(), 0);

    // Overrun: drop, clear, then simultaneous drop+clear.
    run_frame(rand_bus(), 2);
    clr_overrun = 1'b1;
    @(negedge clk);
    clr_overrun = 1'b0;
    exp_ovr = 1'b0;
    check_eq("overrun_cleared", {31'd0, overrun}, 32'd0);
    run_frame(rand_bus(), 3);
    clr_overrun = 1'b1;
    @(negedge clk);
    clr_overrun = 1'b0;
    exp_ovr = 1'b0;

    // Snapshot isolation.
    run_frame(seq_bus, 1);

    // Counter wrap with a faster, jittery SPI master.
    for (int f = 0; f < 256; f++) begin
      rise_dly = $urandom_range(1, 5);
      run_frame(rand_bus(), 0);
    end
    rise_dly = 16;

    // Reset in the middle of the data phase.
    rx_q.delete();
    data_bus = rand_bus();
    fft_done = 1'b1;
    @(negedge clk);
    fft_done = 1'b0;
    k = 0;
    while (rx_q.size() < 4 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check_eq("reached_data_phase", {31'd0, rx_q.size() >= 4}, 32'd1);
    s0 = sent_cnt;
    i_Rst_L = 1'b0;
    #1;
    check_eq("midrst_tx_byte", {24'd0, tx_byte}, 32'd0);
    check_eq("midrst_tx_dv", {31'd0, tx_dv}, 32'd0);
    check_eq("midrst_busy", {31'd0, busy}, 32'd0);
    check_eq("midrst_frame_sent", {31'd0, frame_sent}, 32'd0);
    check_eq("midrst_overrun", {31'd0, overrun}, 32'd0);
    @(negedge clk);
    i_Rst_L = 1'b1;
    repeat (40) @(negedge clk);
    check_eq("no_frame_sent_after_rst", sent_cnt - s0, 32'd0);
    check_eq("idle_after_rst", {31'd0, busy}, 32'd0);
    exp_cnt = 8'd0;
    exp_ovr = 1'b0;
    run_frame(seq_bus, 0);
    run_frame(rand_bus(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
